// File: rtl/mod_mul_interleaved.sv
// mod_mul_interleaved: 256-bit (A*B) mod M using MSB-first double-and-add, one multiplier bit per cycle.
module mod_mul_interleaved #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] opM,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a, b, m;
  logic [WIDTH:0] p, mx, t1, t1r, t2, t2r, nxt;
  logic [IW-1:0] i;
  logic m_small;
  assign in_ready = state == IDLE;
  // One extra bit keeps 2P and T+A from overflowing before each conditional subtract.
  always_comb begin
    mx = {1'b0, m};
    t1 = p << 1;
    t1r = t1 >= mx ? t1 - mx : t1;
    t2 = t1r + {1'b0, a};
    t2r = t2 >= mx ? t2 - mx : t2;
    nxt = b[i] ? t2r : t1r;
    m_small = m[WIDTH-1:1] == '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      m <= '0;
      p <= '0;
      i <= IW'(WIDTH - 1);
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a <= opA;
          b <= opB;
          m <= opM;
          p <= '0;
          i <= IW'(WIDTH - 1);
          state <= CALC;
        end
        CALC: begin
          p <= nxt;
          i <= i - 1'b1;
          if (i == '0) begin
            state <= DONE;
            out_valid <= 1'b1;
            out_data <= m_small ? '0 : nxt[WIDTH-1:0];
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_mul_interleaved.sv
// tb_mod_mul_interleaved: directed and random scoreboard bench for mod_mul_interleaved.
module tb_mod_mul_interleaved;
  localparam int W = 256;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] opA = '0, opB = '0, opM = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  int errors = 0, checks = 0, accepts = 0, hs = 0;
  longint cyc = 0, t_acc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] p25519;

  mod_mul_interleaved #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opA(opA), .opB(opB), .opM(opM),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) hs <= hs + 1;
  end

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] r = '0;
    for (int k = 0; k < 8; k++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    logic [2*W-1:0] prod, r;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    r = prod % {{W{1'b0}}, m};
    return r[W-1:0];
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m, input logic [W-1:0] e);
    int n = 0;
    opA = a; opB = b; opM = m; in_valid = 1'b1;
    while (!in_ready && n < 600) begin @(posedge clk); #1; n++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_wait in_ready=%b required=1", in_ready); end
    @(posedge clk); #1;
    t_acc = cyc;
    in_valid = 1'b0;
    accepts++;
    exp_q.push_back(e);
  endtask

  task automatic get_result(input string name, input int stall);
    int n = 0;
    bit busy_bad = 0, stall_bad = 0;
    logic [W-1:0] e, d;
    out_ready = (stall == 0);
    while (!out_valid && n < 700) begin
      if (in_ready) busy_bad = 1;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s_timeout out_valid=%b required=1", name, out_valid);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      out_ready = 1'b0;
      return;
    end
    checks++;
    if (cyc - t_acc != 256) begin errors++; $display("FAIL %s_latency got=%0d required=256", name, cyc - t_acc); end
    checks++;
    if (busy_bad || in_ready !== 1'b0) begin errors++; $display("FAIL %s_in_ready_busy got=1 required=0", name); end
    e = exp_q.size() > 0 ? exp_q.pop_front() : '1;
    checks++;
    if (out_data !== e) begin errors++; $display("FAIL %s_data got=%h required=%h", name, out_data, e); end
    d = out_data;
    if (stall > 0) begin
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || out_data !== d) stall_bad = 1;
      end
      checks++;
      if (stall_bad) begin errors++; $display("FAIL %s_hold out_valid=%b data=%h required=1 %h", name, out_valid, out_data, d); end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== d || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_post_hs out_valid=%b in_ready=%b data=%h required=0 1 %h", name, out_valid, in_ready, out_data, d);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL reset in_ready=%b out_valid=%b data=%h required=1 0 0", in_ready, out_valid, out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_no_valid out_valid=%b in_ready=%b required=0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    issue(3, 5, 7, 1);
    get_result("basic", 0);
  endtask

  task automatic test_field();
    issue(p25519 - 1, p25519 - 1, p25519, 1);
    get_result("field_sq", 0);
    issue(256'd1 << 254, 4, p25519, 38);
    get_result("field_38", 0);
  endtask

  task automatic test_zero();
    issue(p25519 - 1, 0, p25519, 0);
    get_result("zero_b", 0);
    issue(0, 0, 1, 0);
    get_result("degenerate", 0);
  endtask

  task automatic test_backpressure();
    issue(6, 3, 7, 4);
    get_result("backpressure", 10);
  endtask

  task automatic test_ignored_input();
    issue(3, 5, 7, 1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      opA = W'($urandom()); opB = W'($urandom()); opM = W'($urandom());
    end
    in_valid = 1'b0;
    get_result("ignored", 0);
  endtask

  task automatic test_reset_mid();
    issue(3, 5, 7, 1);
    repeat (100) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid out_valid=%b data=%h in_ready=%b required=0 0 1", out_valid, out_data, in_ready);
    end
    exp_q.delete();
    accepts--;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_spurious out_valid=%b required=0", out_valid); end
    issue(6, 6, 7, 1);
    get_result("after_reset", 0);
  endtask

  task automatic test_random(input int n_ops);
    logic [W-1:0] a, b, m;
    for (int k = 0; k < n_ops; k++) begin
      m = rnd256() | 1 | (256'd1 << 255);
      a = rnd256() % m;
      b = rnd256() % m;
      issue(a, b, m, ref_mod(a, b, m));
      get_result("random", $urandom_range(0, 3));
    end
    checks++;
    if (hs != accepts) begin errors++; $display("FAIL handshake_count got=%0d required=%0d", hs, accepts); end
  endtask

  initial begin
    p25519 = (256'd1 << 255) - 256'd19;
    test_reset();
    test_basic();
    test_field();
    test_zero();
    test_backpressure();
    test_ignored_input();
    test_reset_mid();
    test_random(150);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
